// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath/memory.
// The master side (the FSM) reads the opcode and memory ready, and drives every enable and select.
interface mips_multicycle_control_if;
   logic [5:0] Op;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       MemtoReg;
   logic       IRWrite;
   logic [1:0] PCSource;
   logic [1:0] ALUOp;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       RegWrite;
   logic       RegDst;
   logic       illegal_op;
   logic       mem_err;
   logic       instr_done;
   logic [3:0] state;

   modport master (
      input  Op, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
             illegal_op, mem_err, instr_done, state
   );

   modport slave (
      output Op, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
             PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
             illegal_op, mem_err, instr_done, state
   );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: fetch/decode/execute/memory/writeback
// sequencing, datapath enables and selects, and a timed wait on unified memory.
module mips_multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   mips_multicycle_control_if.master  ctl
);

   typedef enum logic [3:0] {
      S_RST     = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADDR = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_RCOMP   = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_ADDIEX  = 4'd11,
      S_ADDIWB  = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [TO_W-1:0] TO_VAL = TO_W'(MEM_TIMEOUT);
   localparam bit              TO_EN  = (MEM_TIMEOUT != 0);

   state_e          state_q, state_d;
   logic [TO_W-1:0] wait_q, wait_d;
   logic            wait_st;
   logic            timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RST;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Only the three memory-facing states can stall on mem_ready, hence only they can time out.
   assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign timeout = TO_EN && wait_st && !ctl.mem_ready && (wait_q == TO_VAL);

   always_comb begin
      state_d         = state_q;
      ctl.PCWrite     = 1'b0;
      ctl.PCWriteCond = 1'b0;
      ctl.IorD        = 1'b0;
      ctl.MemRead     = 1'b0;
      ctl.MemWrite    = 1'b0;
      ctl.MemtoReg    = 1'b0;
      ctl.IRWrite     = 1'b0;
      ctl.PCSource    = 2'b00;
      ctl.ALUOp       = 2'b00;
      ctl.ALUSrcA     = 1'b0;
      ctl.ALUSrcB     = 2'b00;
      ctl.RegWrite    = 1'b0;
      ctl.RegDst      = 1'b0;
      ctl.illegal_op  = 1'b0;
      ctl.mem_err     = 1'b0;
      ctl.instr_done  = 1'b0;

      unique case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            ctl.MemRead = 1'b1;
            ctl.ALUSrcB = 2'b01;
            ctl.IRWrite = ctl.mem_ready;
            ctl.PCWrite = ctl.mem_ready;
            if (ctl.mem_ready) state_d = S_DECODE;
            else if (timeout)  state_d = S_FETCH;
         end
         S_DECODE: begin
            ctl.ALUSrcB = 2'b11;
            case (ctl.Op)
               OP_LW, OP_SW: state_d = S_MEMADDR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default: begin
                  state_d        = S_FETCH;
                  ctl.illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADDR: begin
            ctl.ALUSrcA = 1'b1;
            ctl.ALUSrcB = 2'b10;
            state_d     = (ctl.Op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            ctl.MemRead = 1'b1;
            ctl.IorD    = 1'b1;
            if (ctl.mem_ready) state_d = S_MEMWB;
            else if (timeout)  state_d = S_FETCH;
         end
         S_MEMWB: begin
            ctl.RegWrite   = 1'b1;
            ctl.MemtoReg   = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         S_MEMWR: begin
            ctl.MemWrite   = 1'b1;
            ctl.IorD       = 1'b1;
            ctl.instr_done = ctl.mem_ready;
            if (ctl.mem_ready || timeout) state_d = S_FETCH;
         end
         S_EXEC: begin
            ctl.ALUSrcA = 1'b1;
            ctl.ALUOp   = 2'b10;
            state_d     = S_RCOMP;
         end
         S_RCOMP: begin
            ctl.RegDst     = 1'b1;
            ctl.RegWrite   = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         S_BRANCH: begin
            ctl.ALUSrcA     = 1'b1;
            ctl.ALUOp       = 2'b01;
            ctl.PCWriteCond = 1'b1;
            ctl.PCSource    = 2'b01;
            ctl.instr_done  = 1'b1;
            state_d         = S_FETCH;
         end
         S_JUMP: begin
            ctl.PCWrite    = 1'b1;
            ctl.PCSource   = 2'b10;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         S_ADDIEX: begin
            ctl.ALUSrcA = 1'b1;
            ctl.ALUSrcB = 2'b10;
            state_d     = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctl.RegWrite   = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
         end
         default: state_d = S_RST;
      endcase

      ctl.mem_err = timeout;
   end

   // Any state change (including a timeout re-entering FETCH) restarts the wait count.
   always_comb begin
      wait_d = wait_q;
      if ((state_d != state_q) || timeout) wait_d = '0;
      else if (wait_st && !ctl.mem_ready)  wait_d = wait_q + 1'b1;
   end

   assign ctl.state = state_q;

endmodule
